// File: rtl/square_root_unit.sv
// Iterative integer square-root engine using the restoring digit-by-digit method.
// It resolves one root bit per clock and holds the result, with a valid level,
// until the next request is accepted. The trial-division prime detector uses
// that valid level to bound its divisor sweep.
module square_root_unit #(
  parameter  int WIDTH     = 32,
  localparam int ROOT_BITS = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] TestNumber,
  output logic [WIDTH-1:0] SquareRootValue,
  output logic [ROOT_BITS+1:0] Remainder,
  output logic             Busy,
  output logic             EnableFromSquareRootCircuit
);

  localparam int REM_W  = ROOT_BITS + 2;
  localparam int ITER_W = (ROOT_BITS > 1) ? $clog2(ROOT_BITS) : 1;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ROOT_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

  typedef struct packed {
    logic [REM_W-1:0]     rem;
    logic [ROOT_BITS-1:0] root;
  } stepT;

  // One restoring step: bring down the next operand bit pair and try to
  // subtract (4*root + 1). A remainder never exceeds 2*root, so REM_W bits
  // hold every intermediate value without loss.
  function automatic stepT restoreStep(
    input logic [REM_W-1:0]     remIn,
    input logic [1:0]           pair,
    input logic [ROOT_BITS-1:0] rootIn
  );
    logic [REM_W-1:0] remT;
    logic [REM_W-1:0] trial;
    stepT             res;
    remT  = (remIn << 2) | {{(REM_W-2){1'b0}}, pair};
    trial = {rootIn, 2'b01};
    if (remT >= trial) begin
      res.rem  = remT - trial;
      res.root = (rootIn << 1) | {{(ROOT_BITS-1){1'b0}}, 1'b1};
    end else begin
      res.rem  = remT;
      res.root = rootIn << 1;
    end
    return res;
  endfunction

  stateT                state;
  stateT                stateNext;
  logic                 busyNext;
  logic                 enableNext;
  logic                 accept;
  logic                 lastIter;

  logic [WIDTH-1:0]     opSr;
  logic [REM_W-1:0]     rem;
  logic [ROOT_BITS-1:0] root;
  logic [ITER_W-1:0]    iter;
  stepT                 step;

  assign accept   = Start && ((state == IDLE) || (state == DONE));
  assign lastIter = (state == CALC) && (iter == LAST_ITER);
  assign step     = restoreStep(rem, opSr[WIDTH-1:WIDTH-2], root);

  // State register plus registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                       <= IDLE;
      Busy                        <= 1'b0;
      EnableFromSquareRootCircuit <= 1'b0;
    end else begin
      state                       <= stateNext;
      Busy                        <= busyNext;
      EnableFromSquareRootCircuit <= enableNext;
    end
  end

  // Next-state and status decode; a Start seen while iterating is dropped.
  always_comb begin
    stateNext  = state;
    busyNext   = Busy;
    enableNext = EnableFromSquareRootCircuit;
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          stateNext  = CALC;
          busyNext   = 1'b1;
          enableNext = 1'b0;
        end
      end
      CALC: begin
        if (iter == LAST_ITER) begin
          stateNext  = DONE;
          busyNext   = 1'b0;
          enableNext = 1'b1;
        end
      end
      default: begin
        stateNext  = IDLE;
        busyNext   = 1'b0;
        enableNext = 1'b0;
      end
    endcase
  end

  // Operand shift register, partial root/remainder and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opSr <= '0;
      rem  <= '0;
      root <= '0;
      iter <= '0;
    end else if (accept) begin
      opSr <= TestNumber;
      rem  <= '0;
      root <= '0;
      iter <= '0;
    end else if (state == CALC) begin
      opSr <= opSr << 2;
      rem  <= step.rem;
      root <= step.root;
      iter <= iter + 1'b1;
    end
  end

  // Result registers change only when the final iteration lands, so the
  // detector sees a stable root for as long as the block sits in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SquareRootValue <= '0;
      Remainder       <= '0;
    end else if (lastIter) begin
      SquareRootValue <= {{(WIDTH-ROOT_BITS){1'b0}}, step.root};
      Remainder       <= step.rem;
    end
  end

endmodule

// File: tb/tb_square_root_unit.sv
// Directed bench for square_root_unit: reset, latency, back-to-back requests,
// extreme operands, ignored restarts and asynchronous abort.
module tb_square_root_unit;

  localparam int WIDTH = 32;
  localparam int RB    = WIDTH / 2;

  logic             clk;
  logic             rst_n;
  logic             Start;
  logic [WIDTH-1:0] TestNumber;
  logic [WIDTH-1:0] SquareRootValue;
  logic [RB+1:0]    Remainder;
  logic             Busy;
  logic             EnableFromSquareRootCircuit;

  int vectors;
  int miscompares;

  square_root_unit #(.WIDTH(WIDTH)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .Start                       (Start),
    .TestNumber                  (TestNumber),
    .SquareRootValue             (SquareRootValue),
    .Remainder                   (Remainder),
    .Busy                        (Busy),
    .EnableFromSquareRootCircuit (EnableFromSquareRootCircuit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse Start for one rising edge; returns at the falling edge after it.
  task automatic startOp(input logic [WIDTH-1:0] value);
    @(negedge clk);
    TestNumber = value;
    Start      = 1'b1;
    @(negedge clk);
    Start      = 1'b0;
  endtask

  // Count falling edges until Enable rises, bounded at 40.
  task automatic waitDone(output int cycles, output logic sawIdle);
    cycles  = 0;
    sawIdle = 1'b0;
    while (!EnableFromSquareRootCircuit && cycles < 40) begin
      if (!Busy) sawIdle = 1'b1;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (SquareRootValue !== '0) begin
      miscompares++;
      $display("FAIL reset_root: got %0d, expected 0", SquareRootValue);
    end
    vectors++;
    if (Remainder !== '0) begin
      miscompares++;
      $display("FAIL reset_rem: got %0d, expected 0", Remainder);
    end
    vectors++;
    if (Busy !== 1'b0 || EnableFromSquareRootCircuit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: busy=%b enable=%b, expected 0 0", Busy, EnableFromSquareRootCircuit);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int   cycles;
    logic sawIdle;
    startOp(32'd97);
    vectors++;
    if (Busy !== 1'b1 || EnableFromSquareRootCircuit !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_accept: busy=%b enable=%b, expected 1 0", Busy, EnableFromSquareRootCircuit);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (SquareRootValue !== '0) begin
      miscompares++;
      $display("FAIL basic_hold_during_calc: root=%0d, expected 0", SquareRootValue);
    end
    waitDone(cycles, sawIdle);
    cycles += 5;
    vectors++;
    if (cycles != RB || sawIdle) begin
      miscompares++;
      $display("FAIL basic_latency: cycles=%0d idleSeen=%b, expected %0d 0", cycles, sawIdle, RB);
    end
    vectors++;
    if (SquareRootValue !== 32'd9 || Remainder !== 18'd16 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: root=%0d rem=%0d busy=%b, expected 9 16 0", SquareRootValue, Remainder, Busy);
    end
    repeat (100) @(negedge clk);
    vectors++;
    if (EnableFromSquareRootCircuit !== 1'b1 || SquareRootValue !== 32'd9 || Remainder !== 18'd16) begin
      miscompares++;
      $display("FAIL basic_hold: enable=%b root=%0d rem=%0d, expected 1 9 16", EnableFromSquareRootCircuit, SquareRootValue, Remainder);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ops   [4] = '{32'd0, 32'd1, 32'd15, 32'd16};
    logic [WIDTH-1:0] roots [4] = '{32'd0, 32'd1, 32'd3,  32'd4};
    logic [RB+1:0]    rems  [4] = '{18'd0, 18'd0, 18'd6,  18'd0};
    int   cycles;
    logic sawIdle;
    for (int i = 0; i < 4; i++) begin
      startOp(ops[i]);
      vectors++;
      if (EnableFromSquareRootCircuit !== 1'b0 || Busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_drop[%0d]: enable=%b busy=%b, expected 0 1", i, EnableFromSquareRootCircuit, Busy);
      end
      waitDone(cycles, sawIdle);
      vectors++;
      if (cycles != RB || sawIdle || SquareRootValue !== roots[i] || Remainder !== rems[i]) begin
        miscompares++;
        $display("FAIL b2b_result[%0d]: cycles=%0d root=%0d rem=%0d, expected %0d %0d %0d",
                 i, cycles, SquareRootValue, Remainder, RB, roots[i], rems[i]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [WIDTH-1:0] ops   [2] = '{32'hFFFF_FFFF, 32'hFFFE_0001};
    logic [RB+1:0]    rems  [2] = '{18'd131070, 18'd0};
    int   cycles;
    logic sawIdle;
    for (int i = 0; i < 2; i++) begin
      startOp(ops[i]);
      waitDone(cycles, sawIdle);
      vectors++;
      if (cycles != RB || SquareRootValue !== 32'd65535 || Remainder !== rems[i]) begin
        miscompares++;
        $display("FAIL extreme[%0d]: cycles=%0d root=%0d rem=%0d, expected %0d 65535 %0d",
                 i, cycles, SquareRootValue, Remainder, RB, rems[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic busyDrop;
    busyDrop = 1'b0;
    startOp(32'd1000);
    for (int n = 1; n <= RB; n++) begin
      TestNumber = $urandom;
      Start      = (n == 5) || (n == RB);
      @(negedge clk);
      if (n < RB && Busy !== 1'b1) busyDrop = 1'b1;
    end
    Start = 1'b0;
    vectors++;
    if (busyDrop || EnableFromSquareRootCircuit !== 1'b1 || SquareRootValue !== 32'd31 || Remainder !== 18'd39) begin
      miscompares++;
      $display("FAIL ignore_result: busyDrop=%b enable=%b root=%0d rem=%0d, expected 0 1 31 39",
               busyDrop, EnableFromSquareRootCircuit, SquareRootValue, Remainder);
    end
    @(negedge clk);
    vectors++;
    if (EnableFromSquareRootCircuit !== 1'b1 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_completion_start: enable=%b busy=%b, expected 1 0", EnableFromSquareRootCircuit, Busy);
    end
  endtask

  task automatic test_async_abort();
    int   cycles;
    logic sawIdle;
    startOp(32'd1000);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (SquareRootValue !== '0 || Remainder !== '0 || Busy !== 1'b0 || EnableFromSquareRootCircuit !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_outputs: root=%0d rem=%0d busy=%b enable=%b, expected 0 0 0 0",
               SquareRootValue, Remainder, Busy, EnableFromSquareRootCircuit);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (Busy !== 1'b0 || EnableFromSquareRootCircuit !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b enable=%b, expected 0 0", Busy, EnableFromSquareRootCircuit);
    end
    startOp(32'd49);
    waitDone(cycles, sawIdle);
    vectors++;
    if (cycles != RB || SquareRootValue !== 32'd7 || Remainder !== 18'd0) begin
      miscompares++;
      $display("FAIL abort_restart: cycles=%0d root=%0d rem=%0d, expected %0d 7 0",
               cycles, SquareRootValue, Remainder, RB);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Start       = 1'b0;
    TestNumber  = '0;
    rst_n       = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_extremes();
    test_ignore_start();
    test_async_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/square_root_unit.md
Name: square_root_unit

Overview:
- Iterative integer square-root engine. Produces floor(sqrt(TestNumber)) plus a completion flag for the prime-detection datapath.
- Feeds the SquareRootValue / EnableFromSquareRootCircuit inputs of the trial-division detector, which bounds its odd-divisor sweep by the root and starts dividing only once the enable is high.
- One result bit per clock, using the restoring digit-by-digit method.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and at least 4.
- ROOT_BITS, WIDTH/2, number of result bits and iterations. Derived value; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  single-cycle request. Latches TestNumber.
- TestNumber  input  WIDTH  operand. Sampled only on an accepted Start.
- SquareRootValue  output  WIDTH  floor(sqrt(operand)), zero-extended from ROOT_BITS.
- Remainder  output  ROOT_BITS+2  operand minus root squared.
- Busy  output  1  high while iterating.
- EnableFromSquareRootCircuit  output  1  result-valid level, held until the next accepted Start.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. SquareRootValue=0, Remainder=0, Busy=0, EnableFromSquareRootCircuit=0. Internal operand shift register, partial root and iteration counter are all cleared.
- States:
  - IDLE: Start=1 → CALC.
  - CALC: runs for exactly ROOT_BITS cycles, then → DONE.
  - DONE: Start=1 → CALC. Otherwise stay in DONE.
- Accept (Start=1 in IDLE or DONE at edge k):
  - op_sr ← TestNumber, rem ← 0, root ← 0, iter ← 0.
  - Busy=1 and Enable=0 from edge k.
  - SquareRootValue and Remainder keep their old values until completion.
- CALC iteration, one per edge:
  - rem_t = (rem << 2) | op_sr[WIDTH-1:WIDTH-2]; op_sr ← op_sr << 2.
  - trial = (root << 2) | 1, evaluated at ROOT_BITS+2 bits.
  - If rem_t ≥ trial: rem ← rem_t − trial, root ← (root << 1) | 1. Otherwise rem ← rem_t, root ← root << 1.
  - iter ← iter + 1.
- Completion: on the edge performing the iteration with iter = ROOT_BITS−1 (edge k+ROOT_BITS):
  - The final root and rem are written to SquareRootValue and Remainder.
  - Busy=0, Enable=1, state DONE.
  - Latency from Start edge to Enable high is ROOT_BITS cycles (16 at the default).
- Start while in CALC is ignored. No restart, no operand change.
- TestNumber changes outside an accepted Start have no effect.
- Enable and the outputs stay stable for as long as the block is in DONE. This lets the detector sweep divisors for an unbounded time.
- Start in the same cycle as completion: that edge is still CALC, so Start is ignored.
- Arithmetic is unsigned.
  - Remainder never exceeds 2·root, so ROOT_BITS+2 bits suffice.
  - Maximum operand 2^WIDTH−1 gives root 2^ROOT_BITS−1 and remainder 2^(ROOT_BITS+1)−2.
- Reset asserted mid-CALC aborts immediately to the reset values. Start is not remembered across reset.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then Start with TestNumber=97. Busy is high for 16 cycles, then Enable=1, SquareRootValue=9, Remainder=16. Enable is still 1 after 100 idle cycles.
- Back-to-back operands 0, 1, 15, 16, each started from DONE:
  - results (root, rem) = (0,0), (1,0), (3,6), (4,0);
  - Enable drops on each Start edge and rises exactly 16 cycles later.
- TestNumber=0xFFFFFFFF → SquareRootValue=65535, Remainder=131070.
- TestNumber=0xFFFE0001 (65535²) → SquareRootValue=65535, Remainder=0.
- Start with 1000 (root 31). Pulse Start again with 4 at cycle 5, and change TestNumber every cycle. The first completion still happens at cycle 16 with SquareRootValue=31, Remainder=39.
- Start with 1000, then pull rst_n low at cycle 8. All outputs read 0 immediately, without waiting for a clock edge. After release, Start with 49 → SquareRootValue=7, Remainder=0 after 16 cycles.
